// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 restoring divider for the EX stage (optional DIV_ZERO_FAST_EN)
module ex_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               cancel_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_for_ex
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_END  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs;
    logic               neg_q;
    logic               neg_r;

    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     upper;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               cnt_last;
    logic               div_zero;
    logic               start_ok;

`ifdef DIV_ZERO_FAST_EN
    assign div_zero = (opdata2_i == '0);
`else
    assign div_zero = 1'b0;
`endif

    // Operand magnitudes: the core always divides unsigned values, signs are re-applied in END.
    assign sign1 = signed_div_i & opdata1_i[WIDTH-1];
    assign sign2 = signed_div_i & opdata2_i[WIDTH-1];
    assign abs1  = sign1 ? (~opdata1_i + ONE_W) : opdata1_i;
    assign abs2  = sign2 ? (~opdata2_i + ONE_W) : opdata2_i;

    // Trial subtraction on the upper WIDTH+1 bits of the left-shifted {rem, quo}.
    assign upper    = {rem, quo[WIDTH-1]};
    assign diff     = upper - {1'b0, dvs};
    assign cnt_last = (cnt == LAST_C);
    assign start_ok = div_start_i & ~cancel_i;

    // Sign correction, two's complement modulo 2^WIDTH.
    assign quo_fix = neg_q ? (~quo + ONE_W) : quo;
    assign rem_fix = neg_r ? (~rem + ONE_W) : rem;

    // Stall is also masked by reset so the pipeline is released as soon as reset is applied.
    assign stallreq_for_ex = rst & div_start_i & ~ready_o & ~cancel_i;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and result outputs; a flush in END suppresses the result.
    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        result_o  = '0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = div_zero ? S_END : S_ON;
                end
            end
            S_ON: begin
                if (cancel_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt_last) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                state_nxt = S_IDLE;
                if (!cancel_i) begin
                    ready_o  = 1'b1;
                    result_o = {rem_fix, quo_fix};
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch in IDLE, one restoring iteration per cycle in ON.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        cnt <= '0;
                        if (div_zero) begin
                            // Fast divide-by-zero result is the raw dividend, no sign correction.
                            rem   <= opdata1_i;
                            quo   <= '1;
                            dvs   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            rem   <= '0;
                            quo   <= abs1;
                            dvs   <= abs2;
                            neg_q <= sign1 ^ sign2;
                            neg_r <= sign1;
                        end
                    end
                end
                S_ON: begin
                    if (!cancel_i) begin
                        cnt <= cnt + ONE_C;
                        if (!diff[WIDTH]) begin
                            rem <= diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= upper[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard testbench for ex_div
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        div_start_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        cancel_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_for_ex;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    ex_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .div_start_i     (div_start_i),
        .signed_div_i    (signed_div_i),
        .opdata1_i       (opdata1_i),
        .opdata2_i       (opdata2_i),
        .cancel_i        (cancel_i),
        .result_o        (result_o),
        .ready_o         (ready_o),
        .stallreq_for_ex (stallreq_for_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    // Called just after a rising edge; that cycle is T0. Holds start until ready, returns after the END edge.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv,
                          output int stalls, output int rdy_at, output logic [63:0] res);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        div_start_i  = 1'b1;
        exp_q.push_back(expv);
        stalls = 0;
        rdy_at = -1;
        res    = '0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (stallreq_for_ex) stalls++;
            if (ready_o) begin
                rdy_at = t;
                res    = result_o;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        div_start_i = 1'b1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        #3;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
        checks++; if (stallreq_for_ex !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stallreq_for_ex); end
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_divu_basic();
        int st, ra;
        logic [63:0] res, ex;
        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, st, ra, res);
        ex = exp_q.pop_front();
        checks++; if (res !== ex) begin errors++; $display("FAIL divu_100_7_result got=%h exp=%h", res, ex); end
        checks++; if (st !== 33) begin errors++; $display("FAIL divu_100_7_stall got=%0d exp=33", st); end
        checks++; if (ra !== 33) begin errors++; $display("FAIL divu_100_7_ready_at got=%0d exp=33", ra); end
        div_start_i = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL divu_after_end_ready got=%b exp=0", ready_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed();
        logic [31:0] a_t[3] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
        logic [31:0] b_t[3] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [63:0] e_t[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_FFFF_FFFD, 64'h0000_0000_8000_0000};
        int st, ra;
        logic [63:0] res, ex;
        for (int i = 0; i < 3; i++) begin
            do_div(1'b1, a_t[i], b_t[i], e_t[i], st, ra, res);
            ex = exp_q.pop_front();
            checks++; if (res !== ex) begin errors++; $display("FAIL div_signed_%0d_result got=%h exp=%h", i, res, ex); end
            checks++; if (ra !== 33) begin errors++; $display("FAIL div_signed_%0d_ready_at got=%0d exp=33", i, ra); end
        end
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_div_zero();
        int st, ra;
        logic [63:0] res, ex;
        do_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, st, ra, res);
        ex = exp_q.pop_front();
        checks++; if (res !== ex) begin errors++; $display("FAIL divzero_result got=%h exp=%h", res, ex); end
        checks++; if (ra !== ZERO_LAT) begin errors++; $display("FAIL divzero_ready_at got=%0d exp=%0d", ra, ZERO_LAT); end
        checks++; if (st !== ZERO_LAT) begin errors++; $display("FAIL divzero_stall got=%0d exp=%0d", st, ZERO_LAT); end
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_cancel();
        int st, ra, rdy_seen;
        logic [63:0] res, ex;
        rdy_seen = 0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        div_start_i = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (ready_o) rdy_seen++;
            @(posedge clk);
            #1;
        end
        cancel_i = 1'b1;
        @(negedge clk);
        checks++; if (stallreq_for_ex !== 1'b0) begin errors++; $display("FAIL cancel_stall got=%b exp=0", stallreq_for_ex); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL cancel_ready got=%b exp=0", ready_o); end
        checks++; if (rdy_seen !== 0) begin errors++; $display("FAIL cancel_no_ready got=%0d exp=0", rdy_seen); end
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        do_div(1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, st, ra, res);
        ex = exp_q.pop_front();
        checks++; if (res !== ex) begin errors++; $display("FAIL cancel_next_result got=%h exp=%h", res, ex); end
        checks++; if (ra !== 33) begin errors++; $display("FAIL cancel_next_ready_at got=%0d exp=33", ra); end
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int st, ra;
        logic [63:0] res, ex;
        do_div(1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, st, ra, res);
        ex = exp_q.pop_front();
        checks++; if (res !== ex) begin errors++; $display("FAIL b2b_first_result got=%h exp=%h", res, ex); end
        checks++; if (st !== 33) begin errors++; $display("FAIL b2b_first_stall got=%0d exp=33", st); end
        do_div(1'b0, 32'd50, 32'd8, {32'd2, 32'd6}, st, ra, res);
        ex = exp_q.pop_front();
        checks++; if (res !== ex) begin errors++; $display("FAIL b2b_second_result got=%h exp=%h", res, ex); end
        checks++; if (st !== 33) begin errors++; $display("FAIL b2b_second_stall got=%0d exp=33", st); end
        checks++; if (ra !== 33) begin errors++; $display("FAIL b2b_second_ready_at got=%0d exp=33", ra); end
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int st, ra;
        logic [63:0] res, ex;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        div_start_i = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++; if (stallreq_for_ex !== 1'b1) begin errors++; $display("FAIL areset_pre_stall got=%b exp=1", stallreq_for_ex); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (stallreq_for_ex !== 1'b0) begin errors++; $display("FAIL areset_stall got=%b exp=0", stallreq_for_ex); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL areset_ready got=%b exp=0", ready_o); end
        checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL areset_result got=%h exp=0", result_o); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, st, ra, res);
        ex = exp_q.pop_front();
        checks++; if (res !== ex) begin errors++; $display("FAIL areset_redo_result got=%h exp=%h", res, ex); end
        checks++; if (st !== 33) begin errors++; $display("FAIL areset_redo_stall got=%0d exp=33", st); end
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int st, ra;
        logic [63:0] res, ex;
        logic [31:0] a, b;
        logic sgn;
        for (int i = 0; i < 10; i++) begin
            sgn = i[0];
            a = $urandom;
            b = (i % 3 == 0) ? $urandom : $urandom_range(1, 1000);
            if (b == 32'd0) b = 32'd1;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            do_div(sgn, a, b, model(sgn, a, b), st, ra, res);
            ex = exp_q.pop_front();
            checks++; if (res !== ex) begin errors++; $display("FAIL random_%0d_result a=%h b=%h s=%b got=%h exp=%h", i, a, b, sgn, res, ex); end
            checks++; if (ra !== 33) begin errors++; $display("FAIL random_%0d_ready_at got=%0d exp=33", i, ra); end
        end
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
